// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead receive FIFO.
// RXD is double-synchronised; bytes are pushed one cycle after the stop-bit sample.
module uart_rx_fifo #(
    parameter int FREQ_CLK   = 100000000,
    parameter int RX_SPEED   = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RXD,
    input  logic       Data_Read,
    output logic [7:0] Data_Out,
    output logic       Empty,
    output logic       Full,
    output logic       Frame_Err,
    output logic       Overrun
);

    localparam int BIT_CYCLES  = FREQ_CLK / RX_SPEED;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES);
    localparam int AW          = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_XOR  = {1'b1, {AW{1'b0}}};

    if (BIT_CYCLES < 4) begin : g_bad_baud
        $error("uart_rx_fifo: FREQ_CLK/RX_SPEED must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           rxd_m;
    logic           rxd_s;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [7:0]     shreg;
    logic           push_pend;
    logic           bit_done;
    logic           half_done;
    logic           cnt_clr;
    logic           idx_clr;
    logic           shift_en;
    logic           stop_ok;
    logic           stop_bad;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;
    logic [7:0]     last_q;
    logic           pop;
    logic           push_ok;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RXD;
            rxd_s <= rxd_m;
        end
    end

    assign bit_done  = (cnt == BIT_LAST);
    assign half_done = (cnt == HALF_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (!rxd_s) state_nx = S_START;
            end
            S_START: begin
                if (half_done) state_nx = rxd_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_done && idx == 3'd7) state_nx = S_STOP;
            end
            S_STOP: begin
                if (bit_done) state_nx = rxd_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rxd_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
            end
            S_START: begin
                cnt_clr = half_done;
                idx_clr = half_done;
            end
            S_DATA: begin
                cnt_clr  = bit_done;
                shift_en = bit_done;
            end
            S_STOP: begin
                cnt_clr  = bit_done;
                stop_ok  = bit_done & rxd_s;
                stop_bad = bit_done & ~rxd_s;
            end
            S_BREAK: begin
                cnt_clr = 1'b1;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
            Frame_Err <= 1'b0;
        end else begin
            cnt       <= cnt_clr ? '0 : cnt + CNT_ONE;
            push_pend <= stop_ok;
            Frame_Err <= stop_bad;
            if (idx_clr) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rxd_s, shreg[7:1]};
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign Empty   = (wptr == rptr);
    assign Full    = ((wptr ^ rptr) == FULL_XOR);
    assign pop     = Data_Read & ~Empty;
    assign push_ok = push_pend & (~Full | pop);

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= shreg;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wptr    <= '0;
            rptr    <= '0;
            last_q  <= '0;
            Overrun <= 1'b0;
        end else begin
            Overrun <= push_pend & Full & ~pop;
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr   <= rptr + PTR_ONE;
                last_q <= mem[rptr[AW-1:0]];
            end
        end
    end

    // When drained, keep showing the byte that was read last.
    assign Data_Out = Empty ? last_q : mem[rptr[AW-1:0]];

endmodule
